// File: rtl/bus_arbiter.sv
// Round-robin snoop-bus arbiter for four caches: one-hot registered grant,
// per-owner hold timeout, and one-cycle error codes for timeout and bad release.
module bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ERRWIDTH    = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [NUM_MASTERS-1:0] releaseBus,
    output logic [NUM_MASTERS-1:0] busAvailable,
    output logic [1:0]             busOwner,
    output logic                   busBusy,
    output logic [ERRWIDTH-1:0]    errFromBus
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [ERRWIDTH-1:0] ERR_NONE    = ERRWIDTH'(0);
    localparam logic [ERRWIDTH-1:0] ERR_TIMEOUT = ERRWIDTH'(1);
    localparam logic [ERRWIDTH-1:0] ERR_BADREL  = ERRWIDTH'(2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWNED = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
    logic [1:0]             r_owner, w_owner_nxt;
    logic [1:0]             r_last,  w_last_nxt;
    logic [CW-1:0]          r_cnt,   w_cnt_nxt;
    logic [ERRWIDTH-1:0]    r_err,   w_err_nxt;
    logic                   r_busy;
    logic                   w_pick_valid;
    logic [1:0]             w_pick_idx;
    logic                   w_own_rel;
    logic                   w_bad_rel;
    logic                   w_timeout;

    // Round-robin pick: nearest requester after lastOwner wins (scanned far to near)
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_idx   = 2'd0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            if (req[r_last + 2'(k)]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = r_last + 2'(k);
            end else begin
                w_pick_valid = w_pick_valid;
            end
        end
    end

    assign w_own_rel = (r_state == S_OWNED) && ((releaseBus & r_grant) != '0);
    assign w_bad_rel = (r_state == S_OWNED) ? ((releaseBus & ~r_grant) != '0)
                                            : (releaseBus != '0);
    assign w_timeout = (r_state == S_OWNED) && !w_own_rel && (r_cnt == CW'(TIMEOUT - 1));

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        if (w_timeout) begin
            w_err_nxt = ERR_TIMEOUT;
        end else if (w_bad_rel) begin
            w_err_nxt = ERR_BADREL;
        end else begin
            w_err_nxt = ERR_NONE;
        end
        case (r_state)
            S_IDLE: begin
                if (w_pick_valid) begin
                    w_grant_nxt = NUM_MASTERS'(1) << w_pick_idx;
                    w_owner_nxt = w_pick_idx;
                    w_cnt_nxt   = CW'(0);
                    w_state_nxt = S_OWNED;
                end else begin
                    w_grant_nxt = '0;
                end
            end
            S_OWNED: begin
                w_cnt_nxt = r_cnt + CW'(1);
                if (w_own_rel || w_timeout) begin
                    w_grant_nxt = '0;
                    w_last_nxt  = r_owner;
                    w_state_nxt = S_TURN;
                end else begin
                    w_grant_nxt = r_grant;
                end
            end
            S_TURN: begin
                w_grant_nxt = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset leaves cache 0 with first priority
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_owner <= 2'd0;
            r_last  <= 2'(NUM_MASTERS - 1);
            r_cnt   <= CW'(0);
            r_err   <= ERR_NONE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= (w_grant_nxt != '0);
        end
    end

    assign busAvailable = r_grant;
    assign busOwner     = r_owner;
    assign busBusy      = r_busy;
    assign errFromBus   = r_err;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter: reset, round robin, timeout,
// bad release, release/timeout collision and reset during ownership.
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] releaseBus;
    logic [3:0] busAvailable;
    logic [1:0] busOwner;
    logic       busBusy;
    logic [1:0] errFromBus;

    int n_checks = 0;
    int n_fail   = 0;

    bus_arbiter #(.NUM_MASTERS(4), .ERRWIDTH(2), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .req(req), .releaseBus(releaseBus),
        .busAvailable(busAvailable), .busOwner(busOwner),
        .busBusy(busBusy), .errFromBus(errFromBus)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are read 1 time unit after it
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; req = 4'b1111; releaseBus = 4'b0101;
        step(3);
        n_checks++; if (busAvailable !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got=%b exp=0000", busAvailable); end
        n_checks++; if (busBusy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busBusy); end
        n_checks++; if (busOwner !== 2'd0) begin n_fail++; $display("FAIL reset_owner got=%0d exp=0", busOwner); end
        n_checks++; if (errFromBus !== 2'b00) begin n_fail++; $display("FAIL reset_err got=%b exp=00", errFromBus); end
        req = 4'b0000; releaseBus = 4'b0000;
        reset = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        int order[5] = '{0, 1, 2, 3, 0};
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_g = 4'b0001 << order[i];
            step(1);
            n_checks++; if (busAvailable !== exp_g) begin n_fail++; $display("FAIL rr_grant%0d got=%b exp=%b", i, busAvailable, exp_g); end
            n_checks++; if (busOwner !== 2'(order[i]) || busBusy !== 1'b1) begin n_fail++; $display("FAIL rr_owner%0d got=%0d/%b exp=%0d/1", i, busOwner, busBusy, order[i]); end
            step(2);
            releaseBus = exp_g;
            step(1);
            releaseBus = 4'b0000;
            n_checks++; if (busAvailable !== 4'b0000 || errFromBus !== 2'b00) begin n_fail++; $display("FAIL rr_release%0d got=%b err=%b exp=0000 err=00", i, busAvailable, errFromBus); end
            step(1);
            n_checks++; if (busAvailable !== 4'b0000 || busBusy !== 1'b0) begin n_fail++; $display("FAIL rr_turn%0d got=%b busy=%b exp=0000 busy=0", i, busAvailable, busBusy); end
        end
        req = 4'b0000;
    endtask

    task automatic test_single();
        req = 4'b0100;
        step(1);
        n_checks++; if (busAvailable !== 4'b0100 || busOwner !== 2'd2 || busBusy !== 1'b1) begin n_fail++; $display("FAIL single got=%b owner=%0d busy=%b exp=0100 owner=2 busy=1", busAvailable, busOwner, busBusy); end
        releaseBus = 4'b0100;
        step(1);
        releaseBus = 4'b0000; req = 4'b0000;
        step(1);
    endtask

    task automatic test_timeout();
        req = 4'b0010;
        step(1);
        n_checks++; if (busAvailable !== 4'b0010) begin n_fail++; $display("FAIL to_grant got=%b exp=0010", busAvailable); end
        req = 4'b1001;
        step(15);
        n_checks++; if (busAvailable !== 4'b0010 || errFromBus !== 2'b00) begin n_fail++; $display("FAIL to_hold got=%b err=%b exp=0010 err=00", busAvailable, errFromBus); end
        step(1);
        n_checks++; if (busAvailable !== 4'b0000 || busBusy !== 1'b0 || errFromBus !== 2'b01) begin n_fail++; $display("FAIL to_fire got=%b busy=%b err=%b exp=0000 busy=0 err=01", busAvailable, busBusy, errFromBus); end
        step(1);
        n_checks++; if (errFromBus !== 2'b00 || busAvailable !== 4'b0000) begin n_fail++; $display("FAIL to_errclr got=%b err=%b exp=0000 err=00", busAvailable, errFromBus); end
        step(1);
        n_checks++; if (busAvailable !== 4'b1000 || busOwner !== 2'd3) begin n_fail++; $display("FAIL to_next got=%b owner=%0d exp=1000 owner=3", busAvailable, busOwner); end
        releaseBus = 4'b1000;
        step(1);
        releaseBus = 4'b0000; req = 4'b0000;
        step(1);
    endtask

    task automatic test_bad_release();
        req = 4'b0001;
        step(1);
        n_checks++; if (busAvailable !== 4'b0001) begin n_fail++; $display("FAIL bad_grant got=%b exp=0001", busAvailable); end
        releaseBus = 4'b1000;
        step(1);
        releaseBus = 4'b0000;
        n_checks++; if (busAvailable !== 4'b0001 || errFromBus !== 2'b10) begin n_fail++; $display("FAIL bad_owned got=%b err=%b exp=0001 err=10", busAvailable, errFromBus); end
        step(1);
        n_checks++; if (busAvailable !== 4'b0001 || errFromBus !== 2'b00) begin n_fail++; $display("FAIL bad_clear got=%b err=%b exp=0001 err=00", busAvailable, errFromBus); end
        releaseBus = 4'b0001; req = 4'b0000;
        step(1);
        releaseBus = 4'b0000;
        step(1);
        releaseBus = 4'b0100;
        step(1);
        releaseBus = 4'b0000;
        n_checks++; if (busAvailable !== 4'b0000 || errFromBus !== 2'b10) begin n_fail++; $display("FAIL bad_idle got=%b err=%b exp=0000 err=10", busAvailable, errFromBus); end
        step(1);
        n_checks++; if (errFromBus !== 2'b00) begin n_fail++; $display("FAIL bad_idle_clr got=%b exp=00", errFromBus); end
    endtask

    task automatic test_release_timeout();
        req = 4'b0010;
        step(1);
        n_checks++; if (busAvailable !== 4'b0010) begin n_fail++; $display("FAIL rt_grant got=%b exp=0010", busAvailable); end
        step(15);
        releaseBus = 4'b0010;
        step(1);
        releaseBus = 4'b0000;
        n_checks++; if (busAvailable !== 4'b0000 || errFromBus !== 2'b00) begin n_fail++; $display("FAIL rt_collide got=%b err=%b exp=0000 err=00", busAvailable, errFromBus); end
        step(1);
        step(1);
        n_checks++; if (busAvailable !== 4'b0010) begin n_fail++; $display("FAIL rt_regrant got=%b exp=0010", busAvailable); end
        step(15);
        releaseBus = 4'b0100;
        step(1);
        releaseBus = 4'b0000; req = 4'b0000;
        n_checks++; if (busAvailable !== 4'b0000 || errFromBus !== 2'b01) begin n_fail++; $display("FAIL rt_tmo_bad got=%b err=%b exp=0000 err=01", busAvailable, errFromBus); end
        step(1);
    endtask

    task automatic test_reset_mid();
        req = 4'b0100;
        step(1);
        releaseBus = 4'b0100;
        step(1);
        releaseBus = 4'b0000;
        step(2);
        n_checks++; if (busAvailable !== 4'b0100 || busOwner !== 2'd2) begin n_fail++; $display("FAIL rm_grant got=%b owner=%0d exp=0100 owner=2", busAvailable, busOwner); end
        step(1);
        reset = 1'b0;
        step(1);
        n_checks++; if (busAvailable !== 4'b0000 || busBusy !== 1'b0 || busOwner !== 2'd0 || errFromBus !== 2'b00) begin n_fail++; $display("FAIL rm_reset got=%b busy=%b owner=%0d err=%b exp=0000 0 0 00", busAvailable, busBusy, busOwner, errFromBus); end
        reset = 1'b1; req = 4'b1100;
        step(1);
        n_checks++; if (busAvailable !== 4'b0100 || busOwner !== 2'd2) begin n_fail++; $display("FAIL rm_after got=%b owner=%0d exp=0100 owner=2", busAvailable, busOwner); end
        req = 4'b0000;
    endtask

    initial begin
        reset = 1'b0; req = 4'b0000; releaseBus = 4'b0000;
        test_reset();
        test_round_robin();
        test_single();
        test_timeout();
        test_bad_release();
        test_release_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
